icache_axi_refill: RTL and testbench
====================================

# icache_axi_refill

AXI4 read-channel refill engine for the instruction cache. It sits directly downstream of the icache second stage. It accepts either a cached line-miss request or an uncached single-word request. It runs the corresponding AXI read burst, assembles a 256-bit line, and returns it with a one-cycle end pulse for the stage to capture.

## Interface
Parameters:
- `ID_W`, default 4: AXI ID width.
- `AR_ID`, default 0: constant driven on `arid`.

Ports (clock and reset first). One clock; reset is asynchronous and active-low.
- `clk`  in  1  — clock
- `rst_n`  in  1  — async active-low reset
- `axi_req_i`  in  1  — cached miss request (level; sampled only in IDLE)
- `addr_i`  in  32  — line address; bits [4:0] are zero
- `uc_req_i`  in  1  — uncached request (level; sampled only in IDLE)
- `uc_addr_i`  in  32  — uncached word address
- `rend_o`  out  1  — one-cycle pulse: `cacheline_rdata_o` is valid
- `cacheline_rdata_o`  out  256  — assembled line; word k at [32k+31:32k]
- `busy_o`  out  1  — high in any state other than IDLE
- `arid`  out  ID_W  — AXI read-address ID
- `araddr`  out  32  — AXI read address
- `arlen`  out  8  — AXI burst length
- `arsize`  out  3  — AXI beat size
- `arburst`  out  2  — AXI burst type
- `arvalid`  out  1  — AXI read-address valid
- `arready`  in  1  — AXI read-address ready
- `rid`  in  ID_W  — AXI read ID
- `rdata`  in  32  — AXI read data
- `rresp`  in  2  — AXI read response
- `rlast`  in  1  — AXI last beat
- `rvalid`  in  1  — AXI read valid
- `rready`  out  1  — AXI read ready

## Operation
- States are IDLE, AR, R and DONE.
  - IDLE → AR when `uc_req_i | axi_req_i`. The request type and address are latched.
  - AR → R on `arvalid & arready`.
  - R → DONE on `rvalid & rready & rlast`.
  - DONE → IDLE unconditionally.
- Simultaneous `uc_req_i` and `axi_req_i` in IDLE: the uncached request wins. The cached request is ignored and the stage must re-present it.
- Requests are ignored outside IDLE.
- Cached request drives:
  - `araddr = {addr_i[31:5],5'b0}`
  - `arlen = 7`, `arsize = 3'b010`, `arburst = 2'b01` (INCR)
- Uncached request drives:
  - `araddr = uc_addr_i`
  - `arlen = 0`, `arsize = 3'b010`, `arburst = 2'b01`
- `arid = AR_ID` always. `rid` is not checked.
- AR address fields are registered at the IDLE→AR transition. They hold stable while `arvalid` is high.
- `arvalid` = 1 only in AR; it stays high until `arready`.
- `rready` = 1 only in R.
- A 3-bit beat counter is cleared on entry to AR and increments on each accepted R beat. It wraps 7→0, and a cached burst ends at beat 7.
- Cached beat n is written to line word n.
- Uncached beat data is replicated into all 8 words, so any word-select on the consumer side returns it.
- Early `rlast`:
  - The burst ends at that beat.
  - Unwritten words keep their previous contents.
- `rvalid` outside R is ignored.
- `cacheline_rdata_o` holds from DONE until the next R beat overwrites it.

## Timing
- Reset values:
  - `rend_o`, `busy_o`, `arvalid`, `rready` = 0
  - `araddr`, `arlen`, `arsize`, `arburst`, `cacheline_rdata_o` = 0
  - state = IDLE, counter = 0
- Reset asserted mid-burst aborts immediately to IDLE. No `rend_o` is produced.
- Minimum cached latency, with `arready` and `rvalid` always high:
  - request at cycle 0, `arvalid` at cycle 1
  - beats at cycles 2–9, `rend_o` at cycle 10
  - IDLE at cycle 11; a new request is sampled at cycle 11
- Minimum uncached latency: request at cycle 0, `rend_o` at cycle 3.
- `rend_o` is high only in DONE, for exactly one cycle. The line is valid in that cycle and afterwards.
- AR/R stalls (`arready = 0` or `rvalid = 0`) extend the state indefinitely. No timeout.

## Configuration
- `ICACHE_REFILL_ERR_EN` defined:
  - adds output `refill_err_o` (1 bit, reset 0)
  - an internal sticky flag is set by any accepted beat with `rresp != 2'b00` and cleared on entry to AR
  - `refill_err_o` equals the flag during DONE and is 0 otherwise
- Not defined: `rresp` is ignored and the port `refill_err_o` does not exist.

## Test plan
- Cached refill:
  - stimulus: `axi_req_i`, `addr_i = 0x1FC0_0020`, beats 0x1000+n, ready/valid always high
  - response: `araddr = 0x1FC0_0020`, `arlen = 7`; `rend_o` at cycle 10; word n = 0x1000+n
- Uncached read:
  - stimulus: `uc_addr_i = 0xBFC0_0004`, one beat 0xDEADBEEF
  - response: `arlen = 0`; all 8 words = 0xDEADBEEF; `rend_o` at cycle 3
- Priority:
  - stimulus: `uc_req_i` and `axi_req_i` asserted together
  - response: a single transfer with `arlen = 0`, `araddr = uc_addr_i`
- Backpressure:
  - stimulus: `arready` low for 5 cycles, `rvalid` toggling 1010…
  - response: `araddr` stable while `arvalid` is high; all 8 words correct; one `rend_o` pulse
- Reset mid-burst:
  - stimulus: `rst_n` low after beat 3, then a new cached request
  - response: all outputs return to reset values; no `rend_o` from the aborted burst; the new burst completes normally
- With `ICACHE_REFILL_ERR_EN`:
  - stimulus: beat 5 has `rresp = 2'b10`
  - response: `refill_err_o` = 1 in the DONE cycle only; a following clean burst gives `refill_err_o` = 0

Source files
------------

// File: rtl/icache_axi_refill.sv
// AXI4 read-channel refill engine: one cached 8-beat line fill or one uncached word per request.
// Optional ICACHE_REFILL_ERR_EN adds refill_err_o, which flags a non-OKAY rresp seen in the burst.
module icache_axi_refill #(
   parameter int              ID_W  = 4,
   parameter logic [ID_W-1:0] AR_ID = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            axi_req_i,
   input  logic [31:0]     addr_i,
   input  logic            uc_req_i,
   input  logic [31:0]     uc_addr_i,
   output logic            rend_o,
   output logic [255:0]    cacheline_rdata_o,
   output logic            busy_o,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
`ifdef ICACHE_REFILL_ERR_EN
   ,
   output logic            refill_err_o
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] AR   = 2'd1;
   localparam logic [1:0] R    = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0] state;
   logic       is_uc;
   logic [2:0] cnt;
   logic       err_flag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         is_uc             <= 1'b0;
         cnt               <= 3'd0;
         err_flag          <= 1'b0;
         araddr            <= 32'd0;
         arlen             <= 8'd0;
         arsize            <= 3'd0;
         arburst           <= 2'd0;
         cacheline_rdata_o <= 256'd0;
      end else begin
         case (state)
            IDLE: if (uc_req_i | axi_req_i) begin
               state    <= AR;
               cnt      <= 3'd0;
               err_flag <= 1'b0;
               arsize   <= 3'b010;
               arburst  <= 2'b01;
               // Uncached wins a tie; the stage re-presents the cached miss later.
               if (uc_req_i) begin
                  is_uc  <= 1'b1;
                  araddr <= uc_addr_i;
                  arlen  <= 8'd0;
               end else begin
                  is_uc  <= 1'b0;
                  araddr <= {addr_i[31:5], 5'b0};
                  arlen  <= 8'd7;
               end
            end
            AR: if (arready) state <= R;
            R: if (rvalid) begin
               cnt <= cnt + 3'd1;
               // Replicating uncached data lets any consumer word-select see it.
               if (is_uc) cacheline_rdata_o <= {8{rdata}};
               else       cacheline_rdata_o[{cnt, 5'b0} +: 32] <= rdata;
               if (rresp != 2'b00) err_flag <= 1'b1;
               if (rlast) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arid    = AR_ID;
   assign arvalid = (state == AR);
   assign rready  = (state == R);
   assign busy_o  = (state != IDLE);
   assign rend_o  = (state == DONE);

`ifdef ICACHE_REFILL_ERR_EN
   assign refill_err_o = (state == DONE) & err_flag;
`endif

   logic unused_ok;
   assign unused_ok = ^{rid, addr_i[4:0], err_flag, rresp};

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: expected lines are queued at request time
// and compared when rend_o pulses.
module tb_icache_axi_refill;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         axi_req_i = 1'b0, uc_req_i = 1'b0;
   logic [31:0]  addr_i = '0, uc_addr_i = '0;
   logic         rend_o, busy_o, arvalid, rready;
   logic [255:0] cacheline_rdata_o;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arready = 1'b0;
   logic [3:0]   rid = '0;
   logic [31:0]  rdata = '0;
   logic [1:0]   rresp = '0;
   logic         rlast = 1'b0, rvalid = 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
   logic         refill_err_o;
`endif

   icache_axi_refill dut (
      .clk(clk), .rst_n(rst_n), .axi_req_i(axi_req_i), .addr_i(addr_i),
      .uc_req_i(uc_req_i), .uc_addr_i(uc_addr_i), .rend_o(rend_o),
      .cacheline_rdata_o(cacheline_rdata_o), .busy_o(busy_o), .arid(arid),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
      .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
`ifdef ICACHE_REFILL_ERR_EN
      , .refill_err_o(refill_err_o)
`endif
   );

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0, cyc = 0;
   logic [255:0] sb[$];
   logic [255:0] model_line = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rend"}, 256'(rend_o), 256'd0);
      check({tag, "_busy"}, 256'(busy_o), 256'd0);
      check({tag, "_arvalid"}, 256'(arvalid), 256'd0);
      check({tag, "_rready"}, 256'(rready), 256'd0);
      check({tag, "_ar"}, 256'({araddr, arlen, arsize, arburst}), 256'd0);
      check({tag, "_line"}, cacheline_rdata_o, 256'd0);
   endtask

   // One full transaction; err_beat < 0 means all beats OKAY, exp_lat 0 skips the latency check.
   task automatic refill(input string tag, input bit uc, input bit both, input logic [31:0] addr,
                         input int ar_stall, input bit toggle, input logic [31:0] base,
                         input int nbeats, input int err_beat, input int exp_lat);
      logic [255:0] exp;
      logic [255:0] line_now;
      logic [31:0]  ea;
      int c0;
      @(negedge clk);
      c0 = cyc;
      if (uc) begin uc_req_i = 1'b1; uc_addr_i = addr; end
      if (!uc || both) begin axi_req_i = 1'b1; addr_i = uc ? 32'h0000_1240 : addr; end
      ea  = uc ? addr : {addr[31:5], 5'b0};
      exp = model_line;
      for (int i = 0; i < nbeats; i++)
         if (uc) exp = {8{base + 32'(i)}};
         else    exp[32*i +: 32] = base + 32'(i);
      sb.push_back(exp);
      @(negedge clk);
      axi_req_i = 1'b0; uc_req_i = 1'b0;
      check({tag, "_arvalid"}, 256'(arvalid), 256'd1);
      check({tag, "_araddr"}, 256'(araddr), 256'(ea));
      check({tag, "_arlen"}, 256'(arlen), uc ? 256'd0 : 256'd7);
      check({tag, "_arsz_burst_id"}, 256'({arsize, arburst, arid}), 256'({3'b010, 2'b01, 4'd0}));
      for (int s = 0; s < ar_stall; s++) begin
         arready = 1'b0;
         @(negedge clk);
         check({tag, "_stall_ar"}, 256'({arvalid, araddr}), 256'({1'b1, ea}));
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      check({tag, "_rready"}, 256'({arvalid, rready}), 256'b01);
      for (int i = 0; i < nbeats; i++) begin
         if (toggle) begin
            rvalid = 1'b0;
            @(negedge clk);
         end
         rvalid = 1'b1;
         rdata  = base + 32'(i);
         rlast  = (i == nbeats - 1);
         rresp  = (i == err_beat) ? 2'b10 : 2'b00;
         @(negedge clk);
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      check({tag, "_rend"}, 256'(rend_o), 256'd1);
      if (exp_lat > 0) check({tag, "_latency"}, 256'(cyc - c0), 256'(exp_lat));
      if (rend_o === 1'b1 && sb.size() > 0) begin
         line_now = sb.pop_front();
         check({tag, "_line"}, cacheline_rdata_o, line_now);
      end
`ifdef ICACHE_REFILL_ERR_EN
      check({tag, "_err_done"}, 256'(refill_err_o), 256'((err_beat >= 0) && (err_beat < nbeats)));
`endif
      model_line = exp;
      @(negedge clk);
      check({tag, "_idle"}, 256'({rend_o, busy_o}), 256'd0);
      check({tag, "_hold"}, cacheline_rdata_o, exp);
`ifdef ICACHE_REFILL_ERR_EN
      check({tag, "_err_after"}, 256'(refill_err_o), 256'd0);
`endif
   endtask

   initial begin
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      refill("cached", 1'b0, 1'b0, 32'h1FC0_0020, 0, 1'b0, 32'h1000, 8, -1, 10);
      refill("uncached", 1'b1, 1'b0, 32'hBFC0_0004, 0, 1'b0, 32'hDEADBEEF, 1, -1, 3);
      refill("priority", 1'b1, 1'b1, 32'h8000_0010, 0, 1'b0, 32'h5555_AAAA, 1, -1, 3);
      refill("backpressure", 1'b0, 1'b0, 32'h0000_3F40, 5, 1'b1, 32'hA000_0000, 8, -1, 0);
      refill("early_rlast", 1'b0, 1'b0, 32'h0000_0100, 0, 1'b0, 32'h7700_0000, 4, -1, 6);

      // rvalid while idle must not touch the line
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      rvalid = 1'b0;
      check("idle_rvalid", cacheline_rdata_o, model_line);
      check("idle_busy", 256'(busy_o), 256'd0);

      // reset after beat 3 of a cached burst
      axi_req_i = 1'b1; addr_i = 32'h0000_2000;
      @(negedge clk);
      axi_req_i = 1'b0; arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rvalid = 1'b1; rdata = 32'hC0DE_0000 + 32'(i);
         @(negedge clk);
      end
      rvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      @(negedge clk);
      check("midreset_norend", 256'(rend_o), 256'd0);
      rst_n = 1'b1;
      model_line = '0;
      @(negedge clk);
      check("postreset_norend", 256'({rend_o, busy_o}), 256'd0);
      refill("after_reset", 1'b0, 1'b0, 32'h0000_4060, 0, 1'b0, 32'h2200_0000, 8, -1, 10);

`ifdef ICACHE_REFILL_ERR_EN
      refill("err_beat5", 1'b0, 1'b0, 32'h0000_5000, 0, 1'b0, 32'h3300_0000, 8, 5, 10);
      refill("err_clean", 1'b0, 1'b0, 32'h0000_5020, 0, 1'b0, 32'h4400_0000, 8, -1, 10);
`endif

      check("sb_empty", 256'(sb.size()), 256'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
